// File: rtl/rail_sequencer.sv
// rail_sequencer: brings a stack of power rails up in order (enable, wait for
// power-good, settle, next rail) and takes them down in reverse order with a
// fixed dwell between rails. Any loss of power-good on an already-enabled rail
// or a power-good timeout drops every rail at once and latches a fault.
module rail_sequencer #(
    parameter int NUM_RAILS        = 4,
    parameter int TIMEOUT_CYCLES   = 16384,
    parameter int SETTLE_CYCLES    = 256,
    parameter int OFF_DELAY_CYCLES = 1024
) (
    input  logic                 sysclk,
    input  logic                 reset_INV,
    input  logic                 enable,
    input  logic                 fault_clear,
    input  logic [NUM_RAILS-1:0] pg,
    output logic [NUM_RAILS-1:0] rail_en,
    output logic                 all_good,
    output logic                 fault,
    output logic [2:0]           fault_rail,
    output logic [2:0]           state
);

    localparam int MAX_A   = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int MAX_CYC = (MAX_A > OFF_DELAY_CYCLES) ? MAX_A : OFF_DELAY_CYCLES;
    localparam int CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST     = CNT_W'(OFF_DELAY_CYCLES - 1);
    localparam logic [2:0]       LAST_IDX     = 3'(NUM_RAILS - 1);

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_ON        = 3'd3,
        ST_RAMP_DOWN = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    state_t               cur_state;
    state_t               nxt_state;
    logic [2:0]           idx;
    logic [2:0]           nxt_idx;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     nxt_cnt;
    logic [2:0]           nxt_fault_rail;
    logic [NUM_RAILS-1:0] nxt_rail_en;

    logic [NUM_RAILS-1:0] pg_meta;
    logic [NUM_RAILS-1:0] pg_sync;
    logic                 en_meta;
    logic                 en_sync;

    logic                 pg_cur;
    logic                 below_bad;
    logic [2:0]           below_bad_idx;
    logic                 upto_bad;
    logic [2:0]           upto_bad_idx;

    assign state = cur_state;

    // Two-flop synchronisers for the asynchronous power-good and enable inputs
    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            pg_meta <= '0;
            pg_sync <= '0;
            en_meta <= 1'b0;
            en_sync <= 1'b0;
        end else begin
            pg_meta <= pg;
            pg_sync <= pg_meta;
            en_meta <= enable;
            en_sync <= en_meta;
        end
    end

    // Find the active rail's power-good and the lowest enabled rail that lost it
    always_comb begin
        pg_cur        = 1'b0;
        below_bad     = 1'b0;
        below_bad_idx = 3'd0;
        upto_bad      = 1'b0;
        upto_bad_idx  = 3'd0;
        for (int j = NUM_RAILS - 1; j >= 0; j--) begin
            if (j == int'(idx)) begin
                pg_cur = pg_sync[j];
            end
            if (!pg_sync[j] && (j < int'(idx))) begin
                below_bad     = 1'b1;
                below_bad_idx = 3'(j);
            end
            if (!pg_sync[j] && (j <= int'(idx))) begin
                upto_bad      = 1'b1;
                upto_bad_idx  = 3'(j);
            end
        end
    end

    // Next-state logic: faults first, then power-down requests, then progress
    always_comb begin
        nxt_state      = cur_state;
        nxt_idx        = idx;
        nxt_cnt        = cnt;
        nxt_fault_rail = fault_rail;
        case (cur_state)
            ST_OFF: begin
                nxt_idx = 3'd0;
                nxt_cnt = '0;
                if (en_sync) begin
                    nxt_state = ST_RAMP_UP;
                end
            end
            ST_RAMP_UP: begin
                if (below_bad) begin
                    nxt_state      = ST_FAULT;
                    nxt_fault_rail = below_bad_idx;
                end else if (!pg_cur && (cnt == TIMEOUT_LAST)) begin
                    nxt_state      = ST_FAULT;
                    nxt_fault_rail = idx;
                end else if (!en_sync) begin
                    nxt_state = ST_RAMP_DOWN;
                end else if (pg_cur) begin
                    nxt_state = ST_SETTLE;
                end else begin
                    nxt_cnt = cnt + CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (upto_bad) begin
                    nxt_state      = ST_FAULT;
                    nxt_fault_rail = upto_bad_idx;
                end else if (!en_sync) begin
                    nxt_state = ST_RAMP_DOWN;
                end else if (cnt == SETTLE_LAST) begin
                    if (idx == LAST_IDX) begin
                        nxt_state = ST_ON;
                    end else begin
                        nxt_idx   = idx + 3'd1;
                        nxt_state = ST_RAMP_UP;
                    end
                end else begin
                    nxt_cnt = cnt + CNT_W'(1);
                end
            end
            ST_ON: begin
                if (upto_bad) begin
                    nxt_state      = ST_FAULT;
                    nxt_fault_rail = upto_bad_idx;
                end else if (!en_sync) begin
                    nxt_state = ST_RAMP_DOWN;
                end
            end
            ST_RAMP_DOWN: begin
                if (cnt == OFF_LAST) begin
                    nxt_cnt = '0;
                    if (idx == 3'd0) begin
                        nxt_state = ST_OFF;
                    end else begin
                        nxt_idx = idx - 3'd1;
                    end
                end else begin
                    nxt_cnt = cnt + CNT_W'(1);
                end
            end
            ST_FAULT: begin
                nxt_cnt = '0;
                if (fault_clear && !en_sync) begin
                    nxt_state = ST_OFF;
                end
            end
            default: begin
                nxt_state = ST_OFF;
                nxt_idx   = 3'd0;
            end
        endcase
        if (nxt_state != cur_state) begin
            nxt_cnt = '0;
        end
    end

    // Rail enable mask for the coming state: rails 0..idx while powering up or
    // on, only the rails below idx while powering down, none otherwise
    always_comb begin
        nxt_rail_en = '0;
        for (int j = 0; j < NUM_RAILS; j++) begin
            case (nxt_state)
                ST_RAMP_UP, ST_SETTLE, ST_ON: nxt_rail_en[j] = (j <= int'(nxt_idx));
                ST_RAMP_DOWN:                 nxt_rail_en[j] = (j < int'(nxt_idx));
                default:                      nxt_rail_en[j] = 1'b0;
            endcase
        end
    end

    // State, index, counter and all outputs registered together
    always_ff @(posedge sysclk or negedge reset_INV) begin
        if (!reset_INV) begin
            cur_state  <= ST_OFF;
            idx        <= 3'd0;
            cnt        <= '0;
            rail_en    <= '0;
            all_good   <= 1'b0;
            fault      <= 1'b0;
            fault_rail <= 3'd0;
        end else begin
            cur_state  <= nxt_state;
            idx        <= nxt_idx;
            cnt        <= nxt_cnt;
            rail_en    <= nxt_rail_en;
            all_good   <= (nxt_state == ST_ON);
            fault      <= (nxt_state == ST_FAULT);
            fault_rail <= nxt_fault_rail;
        end
    end

endmodule

// File: doc/rail_sequencer.md
RAIL_SEQUENCER -- requirements
Module: rail_sequencer

Interface
REQ-001 Parameter NUM_RAILS, default 4, number of sequenced rails (legal range 1..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 16384, maximum wait for a rail's power-good after its enable asserts.
REQ-003 Parameter SETTLE_CYCLES, default 256, dwell after a rail's power-good before the next rail enables.
REQ-004 Parameter OFF_DELAY_CYCLES, default 1024, dwell after a rail's enable deasserts before the next-lower rail deasserts.
REQ-005 sysclk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset_INV  in  1  reset, asynchronous assert and active-low.
REQ-007 enable  in  1  request power-up when high and power-down when low.
REQ-008 fault_clear  in  1  acknowledges a latched fault.
REQ-009 pg  in  NUM_RAILS  per-rail power-good inputs, asynchronous.
REQ-010 rail_en  out  NUM_RAILS  per-rail enable outputs.
REQ-011 all_good  out  1  high only in ON.
REQ-012 fault  out  1  high only in FAULT.
REQ-013 fault_rail  out  3  index of the rail that caused the last fault.
REQ-014 state  out  3  current state encoding.

Function
REQ-015 pg and enable SHALL each pass through a 2-flop synchroniser, giving 2 cycles of latency; all rules below refer to the synchronised values.
REQ-016 State encoding SHALL be OFF=0, RAMP_UP=1, SETTLE=2, ON=3, RAMP_DOWN=4, FAULT=5; codes 6 and 7 SHALL return to OFF on the next cycle.
REQ-017 A rail index register idx SHALL select the active rail, and rail_en SHALL equal a registered mask with bits 0..idx set in RAMP_UP, SETTLE and ON.
REQ-018 OFF: rail_en=0; when enable is high, set idx=0, clear the counter, and go to RAMP_UP.
REQ-019 RAMP_UP: count cycles; when pg[idx] is high, clear the counter and go to SETTLE.
REQ-020 RAMP_UP timeout: if the counter reaches TIMEOUT_CYCLES-1 without pg[idx], go to FAULT with fault_rail=idx.
REQ-021 SETTLE: after exactly SETTLE_CYCLES cycles, go to ON if idx==NUM_RAILS-1; otherwise increment idx and go to RAMP_UP.
REQ-022 In RAMP_UP, SETTLE and ON, if any pg[j] with j<idx (j<=idx in SETTLE/ON) is low, go to FAULT with fault_rail equal to the lowest such j; this check SHALL take priority over timeout and advance.
REQ-023 enable low in RAMP_UP, SETTLE or ON SHALL go to RAMP_DOWN with idx unchanged; a fault in the same cycle SHALL take priority.
REQ-024 RAMP_DOWN: clear rail_en[idx], wait OFF_DELAY_CYCLES cycles, then decrement idx; after idx 0 completes, go to OFF.
REQ-025 RAMP_DOWN SHALL ignore pg and enable; a re-asserted enable restarts from OFF only after power-down completes.
REQ-026 FAULT: on entry, rail_en SHALL go to 0 on the same edge (all rails at once), and fault and fault_rail SHALL hold.
REQ-027 FAULT SHALL exit to OFF only when fault_clear is high while enable is low; fault_rail SHALL retain its value until the next fault.
REQ-028 The counter width SHALL be clog2 of the largest of the three cycle parameters, and the counter SHALL clear on every state transition.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 While reset_INV is low: state=OFF, idx=0, counter=0, synchronisers=0, rail_en=0, all_good=0, fault=0, fault_rail=0.
REQ-031 Reset asserted mid-sequence SHALL drop all rail_en immediately (asynchronously).
REQ-032 After reset release, the block SHALL stay in OFF until synchronised enable is high.

Verification (NUM_RAILS=3, TIMEOUT_CYCLES=20, SETTLE_CYCLES=4, OFF_DELAY_CYCLES=5)
REQ-033 Nominal power-up: enable=1, each pg[i] returns 3 cycles after rail_en[i] -> rail_en steps 001, 011, 111 -> all_good=1, state=3.
REQ-034 Timeout: pg[1] never asserts -> exactly 20 cycles after RAMP_UP entry for rail 1: fault=1, fault_rail=1, rail_en=000; fault_clear with enable=1 is ignored, and with enable=0 -> state=0.
REQ-035 Brown-out in ON: pg[0] drops -> state=5, fault_rail=0, rail_en=000 within 3 cycles of the pg edge.
REQ-036 Power-down from ON: enable=0 -> rail_en steps 011, 001, 000 at 5-cycle spacing -> state=0.
REQ-037 Abort: enable=0 while in SETTLE of rail 1 -> RAMP_DOWN from idx=1 (011 -> 001 -> 000), with no fault raised.
REQ-038 Reset mid-ramp: reset_INV low with rail_en=011 -> rail_en=000 asynchronously; after release, state=0.
